// File: rtl/piezo_phase_capture.sv
// Captures the phase of each piezo feedback line against the drive-period counter
// for one armed period. The results are read back over an Avalon-MM slave with read latency 1.
//
// state     | meaning
// IDLE      | not armed
// WAIT_SYNC | armed, waiting for the next period start
// CAPTURE   | latching the first rising edge of each channel for one period
// DONE      | one-cycle frame end, missing count latched
module piezo_phase_capture #(
  parameter int NUM_CH        = 89,
  parameter int PERIOD_CYCLES = 1250,
  parameter int CNT_W         = 11,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] piezo_in,
  input  logic              period_sync,
  input  logic [7:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq
);

  localparam int               MISS_W     = $clog2(NUM_CH + 1);
  localparam int               IDX_W      = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [7:0]       PHASE_BASE = 8'h10;
  localparam logic [8:0]       PHASE_END  = 9'(16 + NUM_CH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                              state, state_nxt;
  logic [CNT_W-1:0]                    cnt;
  logic                                period_start;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0]  sync_q;
  logic [NUM_CH-1:0]                   prev;
  logic [NUM_CH-1:0]                   rise;
  logic [NUM_CH-1:0]                   cap;
  logic [NUM_CH-1:0]                   valid;
  logic [CNT_W-1:0]                    phase [NUM_CH];
  logic [MISS_W-1:0]                   missing;
  logic [MISS_W-1:0]                   miss_cnt;
  logic                                irq_en;
  logic                                continuous;
  logic                                done;
  logic                                busy;
  logic                                clear_frame;
  logic                                end_frame;
  logic                                wr_ctrl;
  logic                                wr_status;
  logic                                arm;
  logic                                in_phase_range;
  logic [IDX_W-1:0]                    phase_idx;
  logic [31:0]                         rd_mux;
  logic                                unused_wdata;

  assign unused_wdata = ^avs_writedata[31:3];

  assign period_start = period_sync | (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (period_start) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev   <= '0;
    end else begin
      sync_q[0] <= piezo_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev;
  assign cap  = (state == CAPTURE) ? (rise & ~valid) : '0;

  assign wr_ctrl   = avs_write && (avs_address == 8'h00);
  assign wr_status = avs_write && (avs_address == 8'h01);
  assign arm       = wr_ctrl && avs_writedata[0];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clear_frame = 1'b0;
    end_frame   = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          state_nxt   = WAIT_SYNC;
          clear_frame = 1'b1;
        end
      end
      WAIT_SYNC: begin
        if (period_start) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (period_start) begin
          state_nxt = DONE;
          end_frame = 1'b1;
        end
      end
      DONE: begin
        if (continuous) begin
          state_nxt   = WAIT_SYNC;
          clear_frame = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Edges captured in the closing cycle still count as present.
  always_comb begin
    miss_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!valid[i] && !cap[i]) miss_cnt = miss_cnt + MISS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      for (int i = 0; i < NUM_CH; i++) phase[i] <= '0;
    end else if (clear_frame) begin
      valid <= '0;
      for (int i = 0; i < NUM_CH; i++) phase[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap[i]) begin
          valid[i] <= 1'b1;
          phase[i] <= cnt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      missing <= '0;
    end else if (clear_frame) begin
      missing <= '0;
    end else if (end_frame) begin
      missing <= miss_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en     <= 1'b0;
      continuous <= 1'b0;
    end else if (wr_ctrl) begin
      irq_en     <= avs_writedata[1];
      continuous <= avs_writedata[2];
    end
  end

  // A frame end in the same cycle as a clear keeps done set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b0;
    end else if (end_frame) begin
      done <= 1'b1;
    end else if (wr_status && avs_writedata[1]) begin
      done <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= done & irq_en;
    end
  end

  assign in_phase_range = ({1'b0, avs_address} >= {1'b0, PHASE_BASE}) &&
                          ({1'b0, avs_address} < PHASE_END);
  assign phase_idx      = IDX_W'(avs_address - PHASE_BASE);

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      8'h00: rd_mux[2:0] = {continuous, irq_en, 1'b0};
      8'h01: rd_mux[3:0] = {state, done, busy};
      8'h02: rd_mux[MISS_W-1:0] = missing;
      8'h03: rd_mux = {8'd0, 8'(NUM_CH), 16'(PERIOD_CYCLES)};
      default: begin
        if (in_phase_range) begin
          rd_mux[31]        = valid[phase_idx];
          rd_mux[CNT_W-1:0] = phase[phase_idx];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

endmodule
